// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline.
// Contents: datapath width, opcode field width, bubble encoding, default reset PC,
// and the next-PC source encoding used by the fetch stage.
package mips_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPCODE_W = 6;

  // sll $0,$0,0: opcode 0 decodes as an R-type with no side effects.
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Next-PC source, reset is handled separately in the PC register.
  typedef enum logic [1:0] {
    PcSelSeq,
    PcSelHold,
    PcSelJump,
    PcSelBranch
  } pc_sel_e;

  // Clear the two byte-offset bits so redirect targets are always word-aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register holding instruction, PC+4 and a valid flag.
// Ports:
//   i_clk        clock, rising edge
//   i_clr        synchronous clear to a bubble; wins over i_en
//   i_en         load enable (deasserted to stall)
//   i_instr      instruction to load
//   i_pc_plus4   PC+4 of that instruction
//   i_valid      valid flag to load
//   o_instr      registered instruction (NOP_INSTR when bubble)
//   o_pc_plus4   registered PC+4 (0 when bubble)
//   o_valid      registered valid flag
module if_id_reg
  import mips_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic            i_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_en) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= i_valid;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// a saturating count of instructions accepted into IF/ID.
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   stall_f                          hold PC and IF/ID
//   flush_d                          load a bubble into IF/ID
//   branch_taken_d, branch_target_d  branch redirect from decode
//   jump_d, jump_target_d            jump redirect from decode (wins over branch)
//   imem_addr, imem_rdata            instruction memory, combinational read
//   pc_f                             current fetch PC
//   instr_d, opcode_d, pc_plus4_d    IF/ID contents (opcode_d = instr_d[31:26])
//   valid_d                          1 = real instruction, 0 = bubble
//   fetch_count                      instructions loaded into IF/ID, saturating
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_f,
  input  logic                flush_d,
  input  logic                branch_taken_d,
  input  logic [XLEN-1:0]     branch_target_d,
  input  logic                jump_d,
  input  logic [XLEN-1:0]     jump_target_d,
  output logic [XLEN-1:0]     imem_addr,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic [XLEN-1:0]     pc_f,
  output logic [XLEN-1:0]     instr_d,
  output logic [OPCODE_W-1:0] opcode_d,
  output logic [XLEN-1:0]     pc_plus4_d,
  output logic                valid_d,
  output logic [XLEN-1:0]     fetch_count
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_fetch_count;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  pc_sel_e         w_pc_sel;
  logic            w_redirect;
  logic            w_ifid_clr;
  logic            w_ifid_load;
  logic            w_unused_lsbs;

  // Redirects are ignored under stall; decode re-presents them afterwards.
  assign w_redirect = ~stall_f & (jump_d | branch_taken_d);
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_pc_sel = PcSelSeq;
    if (stall_f)             w_pc_sel = PcSelHold;
    else if (jump_d)         w_pc_sel = PcSelJump;
    else if (branch_taken_d) w_pc_sel = PcSelBranch;
  end

  always_comb begin
    w_pc_next = w_pc_plus4;
    unique case (w_pc_sel)
      PcSelHold:   w_pc_next = r_pc;
      PcSelJump:   w_pc_next = word_align(jump_target_d);
      PcSelBranch: w_pc_next = word_align(branch_target_d);
      default:     w_pc_next = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_pc_next;
  end

  // A redirect also squashes the wrong-path word fetched this cycle (no delay slot).
  assign w_ifid_clr  = rst | flush_d | w_redirect;
  assign w_ifid_load = ~w_ifid_clr & ~stall_f;

  if_id_reg u_if_id_reg (
    .i_clk      (clk),
    .i_clr      (w_ifid_clr),
    .i_en       (~stall_f),
    .i_instr    (imem_rdata),
    .i_pc_plus4 (w_pc_plus4),
    .i_valid    (1'b1),
    .o_instr    (instr_d),
    .o_pc_plus4 (pc_plus4_d),
    .o_valid    (valid_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_ifid_load && (r_fetch_count != '1)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign w_unused_lsbs = ^{jump_target_d[1:0], branch_target_d[1:0]};

  assign imem_addr   = r_pc;
  assign pc_f        = r_pc;
  assign opcode_d    = instr_d[31:26];
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A reference model predicts the PC and
// IF/ID contents for every cycle; the predicted IF/ID entry is queued when the
// inputs are driven and popped for comparison after the clock edge.
module tb_fetch_stage;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  logic        clk = 1'b0;
  logic        rst, stall_f, flush_d, branch_taken_d, jump_d;
  logic [31:0] branch_target_d, jump_target_d;
  logic [31:0] imem_addr, imem_rdata, pc_f, instr_d, pc_plus4_d, fetch_count;
  logic [5:0]  opcode_d;
  logic        valid_d;

  logic [31:0] w_imem_addr, w_imem_rdata, w_pc_f, w_instr_d, w_pc_plus4_d, w_fetch_count;
  logic [5:0]  w_opcode_d;
  logic        w_valid_d;

  int n_checks = 0;
  int n_pass   = 0;

  ifid_t       sb_q[$];
  ifid_t       m_ifid;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata   = imem_word(imem_addr);
  assign w_imem_rdata = imem_word(w_imem_addr);

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall_f         (stall_f),
    .flush_d         (flush_d),
    .branch_taken_d  (branch_taken_d),
    .branch_target_d (branch_target_d),
    .jump_d          (jump_d),
    .jump_target_d   (jump_target_d),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .pc_f            (pc_f),
    .instr_d         (instr_d),
    .opcode_d        (opcode_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d),
    .fetch_count     (fetch_count)
  );

  // Second instance to exercise a non-zero reset PC and 32-bit wraparound.
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk             (clk),
    .rst             (rst),
    .stall_f         (stall_f),
    .flush_d         (flush_d),
    .branch_taken_d  (branch_taken_d),
    .branch_target_d (branch_target_d),
    .jump_d          (jump_d),
    .jump_target_d   (jump_target_d),
    .imem_addr       (w_imem_addr),
    .imem_rdata      (w_imem_rdata),
    .pc_f            (w_pc_f),
    .instr_d         (w_instr_d),
    .opcode_d        (w_opcode_d),
    .pc_plus4_d      (w_pc_plus4_d),
    .valid_d         (w_valid_d),
    .fetch_count     (w_fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock: drive inputs, advance the model, queue the expected IF/ID, compare.
  task automatic step(input logic r, input logic st, input logic fl,
                      input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    logic  redir;
    ifid_t exp_e;
    @(negedge clk);
    rst = r; stall_f = st; flush_d = fl;
    branch_taken_d = br; branch_target_d = bt;
    jump_d = j; jump_target_d = jt;
    if (r) begin
      m_pc   = 32'h0;
      m_ifid = '0;
      m_cnt  = 32'h0;
    end else begin
      redir = !st && (j || br);
      if (fl || redir) begin
        m_ifid = '0;
      end else if (!st) begin
        m_ifid = '{instr: imem_word(m_pc), pc4: m_pc + 32'd4, valid: 1'b1};
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      if (st)      m_pc = m_pc;
      else if (j)  m_pc = {jt[31:2], 2'b00};
      else if (br) m_pc = {bt[31:2], 2'b00};
      else         m_pc = m_pc + 32'd4;
    end
    sb_q.push_back(m_ifid);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      exp_e = sb_q.pop_front();
      check("instr_d",    instr_d,            exp_e.instr);
      check("opcode_d",   {26'd0, opcode_d},  {26'd0, exp_e.instr[31:26]});
      check("pc_plus4_d", pc_plus4_d,         exp_e.pc4);
      check("valid_d",    {31'd0, valid_d},   {31'd0, exp_e.valid});
    end
    check("pc_f",        pc_f,        m_pc);
    check("imem_addr",   imem_addr,   m_pc);
    check("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall_f = 1'b0; flush_d = 1'b0;
    branch_taken_d = 1'b0; branch_target_d = '0;
    jump_d = 1'b0; jump_target_d = '0;
    m_pc = '0; m_ifid = '0; m_cnt = '0;

    // Reset, then sequential fetch; wrap instance counts up through 0.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("reset_pc",       pc_f,        32'h0);
    check("reset_valid",    {31'd0, valid_d}, 32'd0);
    check("wrap_reset_pc",  w_pc_f,      32'hFFFF_FFF8);
    run(1);
    check("seq_pc_4",       pc_f,        32'h4);
    check("seq_instr0",     instr_d,     imem_word(32'h0));
    check("wrap_pc_fffc",   w_pc_f,      32'hFFFF_FFFC);
    run(1);
    check("seq_pc_8",       pc_f,        32'h8);
    check("wrap_pc_zero",   w_pc_f,      32'h0);
    check("wrap_pc4_d",     w_pc_plus4_d, 32'h0);

    // Stall 3 cycles at pc 8: PC, IF/ID and count frozen.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall_pc",       pc_f,        32'h8);
    check("stall_instr",    instr_d,     imem_word(32'h4));
    check("stall_count",    fetch_count, 32'd2);
    run(1);
    check("release_pc_c",   pc_f,        32'hC);
    check("count_3",        fetch_count, 32'd3);
    run(1);

    // Taken branch at pc 0x10 to 0x40: one bubble, then imem[0x40].
    check("pre_branch_pc",  pc_f,        32'h10);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    check("branch_pc",      pc_f,        32'h40);
    check("branch_bubble",  {31'd0, valid_d}, 32'd0);
    run(1);
    check("branch_instr",   instr_d,     imem_word(32'h40));
    check("branch_pc4",     pc_plus4_d,  32'h44);

    // Jump beats branch; both ignored under stall; misaligned target is aligned.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
    check("jump_wins",      pc_f,        32'h80);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
    check("redirect_stalled", pc_f,      32'h80);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 32'h0);
    check("misaligned_tgt", pc_f,        32'h40);
    run(2);

    // Flush with stall: bubble, PC held, count unchanged.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("flush_stall_pc", pc_f,        32'h48);
    check("flush_stall_i",  instr_d,     32'h0);
    run(2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    run(1);

    // Reset during a redirect.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300);
    check("rst_redirect_pc", pc_f,       32'h0);
    check("rst_count",      fetch_count, 32'h0);
    check("rst_pc4",        pc_plus4_d,  32'h0);
    run(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS32 core: owns the PC register, next-PC selection and the IF/ID pipeline register. It drives the instruction-memory address and receives the read data combinationally. It presents the decode-stage instruction, whose `instr_d[31:26]` field drives `maindec.opcode`. Branch/jump redirects from decode, hazard-unit stalls and flushes all land here.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall_f`  in  1: hold the PC and IF/ID (load-use hazard from the hazard unit).
- `flush_d`  in  1: load a bubble into IF/ID.
- `branch_taken_d`  in  1: decode resolved a taken branch.
- `branch_target_d`  in  32: branch target address.
- `jump_d`  in  1: decode holds j/jal/jr.
- `jump_target_d`  in  32: jump target address, computed in decode.
- `imem_addr`  out  32: equals `pc_f`.
- `imem_rdata`  in  32: instruction at `imem_addr`, valid in the same cycle.
- `pc_f`  out  32: current fetch PC.
- `instr_d`  out  32: IF/ID instruction.
- `opcode_d`  out  6: `instr_d[31:26]`, routed to maindec.
- `pc_plus4_d`  out  32: PC+4 of the IF/ID instruction, used for branch targets and jal link.
- `valid_d`  out  1: 1 = real instruction in IF/ID; 0 = bubble.
- `fetch_count`  out  32: count of instructions accepted into IF/ID.

## Operation
- **Next-PC selection**, highest priority first:
  - `rst` → `RESET_PC`.
  - `stall_f` → hold.
  - `jump_d` → `{jump_target_d[31:2], 2'b00}`.
  - `branch_taken_d` → `{branch_target_d[31:2], 2'b00}`.
  - otherwise → `pc_f + 4`.
- **Redirect suppression:** jump and branch are ignored while `stall_f=1`. Decode re-presents them once the stall is released.
- **PC arithmetic:** modulo 2^32, so 32'hFFFF_FFFC + 4 = 0. No exception is raised.
- **No architectural delay slot.** A redirect accepted in cycle N (`stall_f=0`) also squashes the wrong-path instruction fetched in cycle N: IF/ID loads a bubble at that edge.
- **IF/ID update priority:**
  - `rst` → bubble.
  - `flush_d` or accepted redirect → bubble.
  - `stall_f` → hold.
  - otherwise → load `imem_rdata`, `pc_f + 4`, `valid_d=1`.
- **Flush wins over stall:** `flush_d=1` with `stall_f=1` gives a bubble in IF/ID while the PC is held.
- **Bubble contents:** `instr_d` = 32'h0000_0000 (sll $0,$0,0, opcode 0, which maindec decodes as R-type with no side effects), `pc_plus4_d`=0, `valid_d=0`.
- **`fetch_count`:** increments by 1 on each edge where IF/ID loads a real instruction. It saturates at 32'hFFFF_FFFF and is cleared only by `rst`.

## Timing
- **Reset values** (first edge with `rst=1`): `pc_f`=`RESET_PC`, `instr_d`=0, `opcode_d`=0, `pc_plus4_d`=0, `valid_d`=0, `fetch_count`=0.
- **Reset mid-operation:** `rst` overrides all other inputs on the same edge; in-flight redirects are discarded.
- **Latency:** the instruction at `pc_f` in cycle N appears on `instr_d` in cycle N+1.
- **Redirect penalty:** one bubble cycle. The target is fetched in cycle N+1 and reaches `instr_d` in cycle N+2.
- **Combinational outputs:** `imem_addr` and `opcode_d` only; no combinational path from any input to any output.

## Structure
- **Shared package `mips_pkg`** holds:
  - `NOP_INSTR` (32'h0)
  - `DEFAULT_RESET_PC`
  - `OPCODE_W` (6)
  - `XLEN` (32)
- **Sub-module `if_id_reg`:** natural split holding `instr`/`pc_plus4`/`valid` with enable (~stall) and synchronous clear (flush | redirect | rst) ports. Reused for later pipeline registers.
- **`fetch_stage`** keeps the PC register, next-PC mux and `fetch_count`.

## Test plan
- **Reset/sequential fetch:** `rst` high 2 cycles then low, imem returns addr-tagged words → `pc_f` 0,4,8,C; `instr_d` lags by one cycle; `valid_d`=1 from cycle 2; `fetch_count`=3 after 4 cycles.
- **Stall:** `stall_f=1` for 3 cycles at `pc_f`=8 → `pc_f`, `instr_d` and `fetch_count` frozen. On release, `pc_f`=C next.
- **Branch:** `branch_taken_d=1`, target 32'h40, at `pc_f`=10 → next `pc_f`=40, `valid_d=0` one cycle, then `instr_d`=imem[40] with `pc_plus4_d`=44.
- **Simultaneous events:**
  - `jump_d=1` (target 80) and `branch_taken_d=1` (target 40) → `pc_f`=80.
  - Same with `stall_f=1` → `pc_f` unchanged.
  - Misaligned target 32'h43 → `pc_f`=40.
- **Flush+stall:** `flush_d=1`, `stall_f=1` → `valid_d=0`, `instr_d`=0, `pc_f` held, `fetch_count` unchanged.
- **Wrap/reset mid-run:**
  - `RESET_PC`=32'hFFFF_FFF8 → `pc_f` FFFF_FFF8, FFFF_FFFC, 0.
  - Assert `rst` during a redirect → `pc_f`=`RESET_PC`, all IF/ID outputs 0.
